// File: rtl/pixel_window_loader.sv
// Loads a 3x3 pixel window from a byte-wide memory, one outstanding read at a time.
// Optional macro BORDER_CLAMP_EN: a shift at the right image edge duplicates the right column instead of being rejected.
module pixel_window_loader #(
  parameter int IMG_WIDTH = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_addr,
  input  logic        start_i_read,
  input  logic        start_shift,
  input  logic        start_move,
  output logic        read_en,
  output logic [15:0] read_addr,
  input  logic        read_valid,
  input  logic [7:0]  read_data,
  output logic        read_data_done,
  output logic        load_done,
  output logic [71:0] window,
  output logic        range_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] base_q;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [1:0]  r_idx;
  logic [1:0]  c_idx;
  logic        full_load;
`ifdef BORDER_CLAMP_EN
  logic        clamp_hold;
`endif

  logic [1:0]  next_r;
  logic [1:0]  next_c;
  logic [3:0]  cap_idx;
  logic        last_read;
  logic        at_edge;
  logic [71:0] shifted_win;

  function automatic logic [15:0] pix_addr(input logic [15:0] base, input logic [9:0] row_v,
                                           input logic [9:0] col_v, input logic [1:0] r,
                                           input logic [1:0] c);
    logic [31:0] sum;
    sum = 32'(base) + (32'(row_v) + 32'(r)) * 32'(IMG_WIDTH) + 32'(col_v) + 32'(c);
    return sum[15:0];
  endfunction

  assign cap_idx   = 4'(r_idx) * 4'd3 + 4'(c_idx);
  assign last_read = (r_idx == 2'd2) && (c_idx == 2'd2);
  assign at_edge   = (32'(col) + 32'd3) == 32'(IMG_WIDTH);

  // Full loads walk the window row by row; shifts only walk down the right column.
  always_comb begin
    next_r = r_idx;
    next_c = c_idx;
    if (full_load) begin
      if (c_idx == 2'd2) begin
        next_c = 2'd0;
        next_r = r_idx + 2'd1;
      end else begin
        next_c = c_idx + 2'd1;
      end
    end else begin
      next_r = r_idx + 2'd1;
    end
  end

  always_comb begin
    shifted_win        = window;
    shifted_win[7:0]   = window[15:8];
    shifted_win[15:8]  = window[23:16];
    shifted_win[31:24] = window[39:32];
    shifted_win[39:32] = window[47:40];
    shifted_win[55:48] = window[63:56];
    shifted_win[63:56] = window[71:64];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base_q         <= '0;
      row            <= '0;
      col            <= '0;
      r_idx          <= '0;
      c_idx          <= '0;
      full_load      <= 1'b0;
      read_en        <= 1'b0;
      read_addr      <= '0;
      read_data_done <= 1'b0;
      load_done      <= 1'b0;
      range_err      <= 1'b0;
      window         <= '0;
`ifdef BORDER_CLAMP_EN
      clamp_hold     <= 1'b0;
`endif
    end else begin
      read_data_done <= 1'b0;
      load_done      <= 1'b0;
      range_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i_read) begin
            base_q    <= base_addr;
            r_idx     <= 2'd0;
            c_idx     <= 2'd0;
            full_load <= 1'b1;
            read_addr <= pix_addr(base_addr, row, col, 2'd0, 2'd0);
            state     <= ISSUE;
          end else if (start_move) begin
            row       <= row + 10'd1;
            col       <= 10'd0;
            r_idx     <= 2'd0;
            c_idx     <= 2'd0;
            full_load <= 1'b1;
            read_addr <= pix_addr(base_q, row + 10'd1, 10'd0, 2'd0, 2'd0);
            state     <= ISSUE;
          end else if (start_shift) begin
            if (at_edge) begin
`ifdef BORDER_CLAMP_EN
              window     <= shifted_win;
              clamp_hold <= 1'b1;
              state      <= DONE;
`else
              range_err  <= 1'b1;
`endif
            end else begin
              window    <= shifted_win;
              col       <= col + 10'd1;
              r_idx     <= 2'd0;
              c_idx     <= 2'd2;
              full_load <= 1'b0;
              read_addr <= pix_addr(base_q, row, col + 10'd1, 2'd0, 2'd2);
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          read_en <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (read_valid) begin
            for (int k = 0; k < 9; k++) begin
              if (cap_idx == 4'(k)) window[8*k +: 8] <= read_data;
            end
            read_data_done <= 1'b1;
            read_en        <= 1'b0;
            if (last_read) begin
              load_done <= 1'b1;
              state     <= DONE;
            end else begin
              r_idx     <= next_r;
              c_idx     <= next_c;
              read_addr <= pix_addr(base_q, row, col, next_r, next_c);
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          // A clamped shift spends one extra cycle here so its load_done lands two cycles after accept.
`ifdef BORDER_CLAMP_EN
          if (clamp_hold) begin
            clamp_hold <= 1'b0;
            load_done  <= 1'b1;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_window_loader.sv
// Scoreboard bench for pixel_window_loader: a reference model predicts read addresses,
// final window and completion latency; a negedge monitor checks them as the DUT produces them.
module tb_pixel_window_loader;

  localparam int W = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base_addr = '0;
  logic        start_i_read = 1'b0;
  logic        start_shift = 1'b0;
  logic        start_move = 1'b0;
  logic        read_en;
  logic [15:0] read_addr;
  logic        read_valid;
  logic [7:0]  read_data;
  logic        read_data_done;
  logic        load_done;
  logic [71:0] window;
  logic        range_err;

  pixel_window_loader #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr),
    .start_i_read(start_i_read), .start_shift(start_shift), .start_move(start_move),
    .read_en(read_en), .read_addr(read_addr), .read_valid(read_valid), .read_data(read_data),
    .read_data_done(read_data_done), .load_done(load_done), .window(window), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read_valid rises after 'waits' cycles of read_en; data is a salted address byte.
  int waits = 0;
  logic [7:0] salt = '0;
  int wcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (read_en && !read_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign read_valid = read_en && (wcnt >= waits);
  assign read_data  = read_addr[7:0] ^ salt;

  typedef struct {
    bit          is_err;
    logic [71:0] win;
    int          lat;
    int          nreads;
    int          acc;
  } exp_t;

  exp_t        res_q[$];
  logic [15:0] addr_q[$];

  int         m_base = 0;
  int         m_row = 0;
  int         m_col = 0;
  logic [7:0] m_p[9];

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack_win();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = m_p[k];
    return w;
  endfunction

  function automatic logic [15:0] model_addr(input int r, input int c);
    int a;
    a = m_base + (m_row + r) * W + m_col + c;
    return 16'(a);
  endfunction

  task automatic model_full();
    exp_t e;
    logic [15:0] a;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a = model_addr(r, c);
        addr_q.push_back(a);
        m_p[3*r+c] = a[7:0] ^ salt;
      end
    end
    e.is_err = 1'b0; e.win = pack_win(); e.lat = 9 * (2 + waits) + 1; e.nreads = 9; e.acc = cyc;
    res_q.push_back(e);
  endtask

  task automatic model_shift();
    exp_t e;
    logic [15:0] a;
    e.acc = cyc;
    if (m_col + 3 == W) begin
`ifdef BORDER_CLAMP_EN
      for (int r = 0; r < 3; r++) begin
        m_p[3*r]   = m_p[3*r+1];
        m_p[3*r+1] = m_p[3*r+2];
      end
      e.is_err = 1'b0; e.lat = 2;
`else
      e.is_err = 1'b1; e.lat = 1;
`endif
      e.nreads = 0;
    end else begin
      m_col++;
      for (int r = 0; r < 3; r++) begin
        m_p[3*r]   = m_p[3*r+1];
        m_p[3*r+1] = m_p[3*r+2];
        a = model_addr(r, 2);
        addr_q.push_back(a);
        m_p[3*r+2] = a[7:0] ^ salt;
      end
      e.is_err = 1'b0; e.lat = 3 * (2 + waits) + 1; e.nreads = 3;
    end
    e.win = pack_win();
    res_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit rd, input bit sh, input bit mv, input logic [15:0] base);
    @(posedge clk); #1;
    start_i_read = rd; start_shift = sh; start_move = mv; base_addr = base;
    @(posedge clk); #1;
    start_i_read = 0; start_shift = 0; start_move = 0;
    if (rd) begin
      m_base = int'(base);
      model_full();
    end else if (mv) begin
      m_row = (m_row + 1) % 1024;
      m_col = 0;
      model_full();
    end else if (sh) begin
      model_shift();
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (res_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (res_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL completion_timeout: got pending=%0d expected pending=0", res_q.size());
      res_q.delete();
      addr_q.delete();
    end
    @(posedge clk);
  endtask

  // Monitor: checks each read address, wait-state holding, and every completion against the queue.
  bit          prev_en = 0;
  bit          prev_valid = 0;
  logic [15:0] prev_addr = '0;
  int          done_cnt = 0;
  int          last_lat = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_en  = 0;
      done_cnt = 0;
    end else begin
      if (prev_en && !prev_valid) begin
        checkOutput("hold_read_en", read_en, 1'b1);
        checkOutput("hold_read_addr", read_addr, prev_addr);
      end
      if (read_data_done) done_cnt++;
      if (read_en && read_valid) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_read: got addr=%h expected no read", read_addr);
        end else begin
          checkOutput("read_addr", read_addr, addr_q.pop_front());
        end
      end
      if (load_done || range_err) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_completion: got load_done=%b range_err=%b expected none",
                   load_done, range_err);
        end else begin
          mon_e = res_q.pop_front();
          last_lat = cyc - mon_e.acc + 1;
          checkOutput("range_err", range_err, mon_e.is_err);
          checkOutput("load_done", load_done, !mon_e.is_err);
          checkOutput("window", window, mon_e.win);
          checkOutput("latency", last_lat, mon_e.lat);
          checkOutput("data_done_count", done_cnt, mon_e.nreads);
        end
        done_cnt = 0;
      end
      prev_en    = read_en;
      prev_valid = read_valid;
      prev_addr  = read_addr;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_read_en"}, read_en, 1'b0);
    checkOutput({tag, "_read_addr"}, read_addr, 16'h0);
    checkOutput({tag, "_read_data_done"}, read_data_done, 1'b0);
    checkOutput({tag, "_load_done"}, load_done, 1'b0);
    checkOutput({tag, "_range_err"}, range_err, 1'b0);
    checkOutput({tag, "_window"}, window, 72'h0);
  endtask

  initial begin
    int n;
    logic [2:0] bits;
    for (int k = 0; k < 9; k++) m_p[k] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 0;

    $display("[TB] directed full load");
    waits = 0; salt = 8'h00;
    applyStimulus(1, 0, 0, 16'h1000);
    waitIdle();
    checkOutput("full_load_window", window, 72'h82_81_80_42_41_40_02_01_00);
    checkOutput("full_load_latency", last_lat, 19);

    $display("[TB] directed shift");
    applyStimulus(0, 1, 0, 16'h0000);
    waitIdle();
    checkOutput("shift_p0", window[7:0], 8'h01);
    checkOutput("shift_p2", window[23:16], 8'h03);
    checkOutput("shift_p8", window[71:64], 8'h83);
    checkOutput("shift_latency", last_lat, 7);

    $display("[TB] wait-state full load");
    waits = 3;
    applyStimulus(1, 0, 0, 16'h1000);
    waitIdle();
    checkOutput("wait_load_latency", last_lat, 46);

    $display("[TB] simultaneous starts and busy move");
    waits = 1; salt = 8'h5a;
    applyStimulus(1, 1, 0, 16'h0400);
    repeat (3) @(posedge clk);
    #1; start_move = 1;
    @(posedge clk); #1; start_move = 0;
    waitIdle();
    applyStimulus(0, 1, 0, 16'h0000);
    waitIdle();

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      waits = $urandom_range(0, 2);
      salt  = 8'($urandom);
      bits  = 3'($urandom_range(1, 7));
      applyStimulus(bits[0], bits[1], bits[2], 16'($urandom));
      waitIdle();
    end

    $display("[TB] reset during fifth read");
    waits = 3; salt = 8'($urandom);
    applyStimulus(1, 0, 0, 16'h3000);
    n = 0;
    while (!(addr_q.size() == 5 && read_en) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fifth_read_reached", (n < 500), 1'b1);
    #2; rst = 1;
    #1;
    checkResetValues("midop_reset");
    res_q.delete(); addr_q.delete();
    m_row = 0; m_col = 0; m_base = 0;
    for (int k = 0; k < 9; k++) m_p[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    repeat (5) @(posedge clk);
    waits = 0;
    applyStimulus(1, 0, 0, 16'h3000);
    waitIdle();

    $display("[TB] right-edge shift");
    waits = 0; salt = 8'h21;
    applyStimulus(1, 0, 0, 16'h2000);
    waitIdle();
    while (m_col < W - 3) begin
      applyStimulus(0, 1, 0, 16'h0000);
      waitIdle();
    end
    applyStimulus(0, 1, 0, 16'h0000);
    waitIdle();
    applyStimulus(0, 1, 0, 16'h0000);
    waitIdle();
    applyStimulus(0, 0, 1, 16'h0000);
    waitIdle();

    $display("[TB] row wrap");
    while (m_row != 1023) begin
      applyStimulus(0, 0, 1, 16'h0000);
      waitIdle();
    end
    applyStimulus(0, 0, 1, 16'h0000);
    waitIdle();
    applyStimulus(0, 1, 0, 16'h0000);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: got still running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
